uart_tx: RTL and testbench

- Serial UART transmitter, 8N1 by default.
- Accepts parallel words through a valid/ready handshake into a small internal FIFO.
- Shifts each word out LSB-first on `tx_o`, framed by one start bit and one or two stop bits.
- Bit timing comes from the shared baud strobe `tick_i`, one strobe per bit period, the same strobe that drives the receive path.
- Sits between the bus-side UART register block and the top-level TX pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx.sv | 90 +++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and default frame constants.
// Contents: uart_tx_state_e (transmit FSM states), UartDataWidth, UartStopBits.
package uart_pkg;
    localparam int UartDataWidth = 8;
    localparam int UartStopBits = 1;
    typedef enum logic [1:0] {Idle, StartBit, DataBits, StopBit} uart_tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding words waiting for the transmitter.
// Ports: clk_i/rst_ni clock and async active-low reset; push/wdata write side
// (ignored when full); pop read side; rdata head word; full, empty, level occupancy.
module uart_tx_fifo #(
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic [DataWidth-1:0]         wdata,
    input  logic                         pop,
    output logic [DataWidth-1:0]         rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FifoDepth):0]   level
);
    localparam int AW = $clog2(FifoDepth);
    logic [DataWidth-1:0] mem [FifoDepth];
    logic [AW:0] wptr, rptr;
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = wptr == rptr;
    assign level = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, LSB-first, one start bit, StopBits stop bits.
// Ports: clk_i/rst_ni clock and async active-low reset; tick_i baud strobe;
// data_i/valid_i/ready_o word handshake into the FIFO; tx_o serial line (idle high);
// busy_o frame or queued data pending; done_o end-of-frame pulse; level_o FIFO occupancy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DataWidth = UartDataWidth,
    parameter int FifoDepth = 4,
    parameter int StopBits  = UartStopBits
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         tick_i,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(FifoDepth):0]   level_o
);
    localparam int BW = $clog2(DataWidth);
    uart_tx_state_e state;
    logic [DataWidth-1:0] shift, head;
    logic [BW-1:0] bit_cnt;
    logic stop_cnt, full, empty, last_stop, pop;
    assign last_stop = stop_cnt == 1'(StopBits - 1);
    // The FIFO head is consumed when a frame starts from idle or follows the last stop bit.
    assign pop = tick_i && !empty && (state == Idle || (state == StopBit && last_stop));
    assign ready_o = !full;
    assign busy_o = state != Idle || !empty;
    uart_tx_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) fifo (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .push(valid_i),
        .wdata(data_i),
        .pop(pop),
        .rdata(head),
        .full(full),
        .empty(empty),
        .level(level_o)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= Idle;
            shift <= '0;
            bit_cnt <= '0;
            stop_cnt <= 1'b0;
            tx_o <= 1'b1;
            done_o <= 1'b0;
        end else begin
            done_o <= tick_i && state == StopBit && last_stop;
            if (tick_i) begin
                case (state)
                    Idle: if (!empty) begin
                        shift <= head;
                        tx_o <= 1'b0;
                        state <= StartBit;
                    end
                    StartBit: begin
                        tx_o <= shift[0];
                        shift <= shift >> 1;
                        bit_cnt <= '0;
                        state <= DataBits;
                    end
                    DataBits: if (bit_cnt == BW'(DataWidth - 1)) begin
                        tx_o <= 1'b1;
                        stop_cnt <= 1'b0;
                        state <= StopBit;
                    end else begin
                        tx_o <= shift[0];
                        shift <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    StopBit: if (!last_stop) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end else if (!empty) begin
                        shift <= head;
                        tx_o <= 1'b0;
                        state <= StartBit;
                    end else begin
                        state <= Idle;
                    end
                    default: state <= Idle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor rebuilds each frame
// from tick-period line levels and compares it with the queued expected word.
module tb_uart_tx;
    logic clk = 0, rst_n = 0, tick = 0, valid = 0;
    logic [7:0] data = 0;
    logic ready, tx, busy, done;
    logic [2:0] level;
    logic tick2 = 1, valid2 = 0;
    logic [7:0] data2 = 0;
    logic ready2, tx2, busy2, done2;
    logic [2:0] level2;
    int passed = 0, total = 0;
    int mode = 0, done_cnt = 0, low_cnt = 0, acc_cnt = 0;
    logic tick_q = 0;
    logic [7:0] exp_q[$];
    bit hist[$];
    bit after_q[$];
    logic [7:0] mon_d;
    logic [9:0] mon_got;

    uart_tx #(.DataWidth(8), .FifoDepth(4), .StopBits(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .data_i(data), .valid_i(valid),
        .ready_o(ready), .tx_o(tx), .busy_o(busy), .done_o(done), .level_o(level));
    uart_tx #(.DataWidth(8), .FifoDepth(4), .StopBits(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick2), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .done_o(done2), .level_o(level2));

    always #5 clk = ~clk;
    always @(posedge clk) tick_q <= tick;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mode != 0) begin
                c = (c + 1) % mode;
                tick = (c == 0);
            end
        end
    end

    // Line monitor: one sample per tick period; on done the preceding ten levels form the frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
        end else begin
            if (tx == 0) low_cnt++;
            if (tick_q) begin
                hist.push_back(tx);
                if (hist.size() > 16) void'(hist.pop_front());
            end
            if (done) begin
                done_cnt++;
                after_q.push_back(tx);
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    mon_d = exp_q.pop_front();
                    for (int i = 0; i < 10; i++) mon_got[i] = hist[hist.size() - 11 + i];
                    chk("frame", mon_got, 10'h200 | ({2'b0, mon_d} << 1));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        logic acc;
        valid = 1;
        data = d;
        acc = ready;
        @(posedge clk);
        #1;
        valid = 0;
        if (acc) begin
            exp_q.push_back(d);
            acc_cnt++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            cyc(1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
        chk("drain_level", level, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int d0, l0, a0, n;
        logic [10:0] got2;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        cyc(2);

        // Two stop bits, tick held high: 11-cycle frame, done in cycle 12.
        valid2 = 1;
        data2 = 8'h81;
        @(posedge clk);
        #1;
        valid2 = 0;
        @(negedge clk);
        chk("sb2_pre", tx2, 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 11) got2[k-1] = tx2;
            chk("sb2_done", done2, k == 12);
        end
        chk("sb2_frame", got2, {2'b11, 8'h81, 1'b0});
        chk("sb2_busy", busy2, 0);
        chk("sb2_level", ready2 && level2 == 0, 1);
        @(posedge clk);
        #1;

        // Single byte.
        mode = 4;
        d0 = done_cnt;
        push(8'hA5);
        drain();
        chk("a5_done_cnt", done_cnt - d0, 1);

        // Back-to-back frames without idle gaps.
        after_q.delete();
        d0 = done_cnt;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        drain();
        chk("b2b_done_cnt", done_cnt - d0, 3);
        chk("b2b_after_cnt", after_q.size(), 3);
        if (after_q.size() == 3) begin
            chk("b2b_gap0", after_q[0], 0);
            chk("b2b_gap1", after_q[1], 0);
            chk("b2b_idle", after_q[2], 1);
        end

        // FIFO full, fifth word discarded, then push refused while popping.
        mode = 0;
        tick = 0;
        cyc(2);
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) push(8'($urandom));
        chk("full_ready", ready, 0);
        chk("full_level", level, 4);
        push(8'hEE);
        chk("full_level_hold", level, 4);
        tick = 1;
        valid = 1;
        data = 8'h77;
        if (ready) exp_q.push_back(8'h77);
        @(posedge clk);
        #1;
        tick = 0;
        valid = 0;
        chk("full_pop_level", level, 3);
        chk("full_pop_ready", ready, 1);
        mode = 4;
        drain();
        chk("full_done_cnt", done_cnt - d0, 4);

        // Reset during data bit 3 with two words queued.
        push(8'h5A);
        push(8'hC3);
        push(8'h96);
        n = 0;
        while (tx != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("mid_start_seen", tx, 0);
        n = 0;
        for (int k = 0; k < 4 && n < 200; ) begin
            cyc(1);
            n++;
            if (tick_q) k++;
        end
        chk("mid_queued", level, 2);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        l0 = low_cnt;
        cyc(80);
        chk("mid_no_done", done_cnt - d0, 0);
        chk("mid_no_frames", low_cnt - l0, 0);
        chk("mid_level", level, 0);

        // Randomized traffic at several tick rates.
        for (int r = 0; r < 3; r++) begin
            mode = $urandom_range(1, 5);
            d0 = done_cnt;
            a0 = acc_cnt;
            for (int k = 0; k < 12; k++) begin
                push(8'($urandom));
                cyc($urandom_range(0, 15));
            end
            drain();
            chk("rand_done_cnt", done_cnt - d0, acc_cnt - a0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
